// File: rtl/inst_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_pkg
// Shared definitions for the instruction fetch queue: FSM state encoding and
// default geometry (queue depth, address width, instruction width).
// No ports; imported by fq_ring and inst_fetch_queue.
// -----------------------------------------------------------------------------
package inst_fetch_queue_pkg;

   localparam int FQ_DEPTH_DEF  = 4;
   localparam int FQ_ADDR_W_DEF = 32;
   localparam int FQ_DATA_W_DEF = 32;

   // RUN: normal operation. DRAIN: discarding responses of flushed fetches.
   typedef enum logic {
      FQ_RUN   = 1'b0,
      FQ_DRAIN = 1'b1
   } fq_state_t;

endpackage

// File: rtl/inst_fetch_queue_fq_ring.sv
// -----------------------------------------------------------------------------
// fq_ring
// DEPTH x W register array with one write port and one asynchronous read
// port, addressed by independent pointers. Used for both the PC ring and the
// instruction data ring of the fetch queue. Contents clear on Reset so the
// read port shows zero until an entry is written.
//
// Ports:
//   CLK      in   clock
//   Reset    in   synchronous active-high reset, clears all entries
//   we       in   write enable
//   wr_ptr   in   write index
//   wr_data  in   write data
//   rd_ptr   in   read index
//   rd_data  out  entry at rd_ptr (combinational)
// -----------------------------------------------------------------------------
module fq_ring
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH_DEF,
   parameter int W     = FQ_DATA_W_DEF
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_ptr,
   input  logic [W-1:0]             wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_ptr,
   output logic [W-1:0]             rd_data
);

   logic [W-1:0] mem_reg [DEPTH];

   always_ff @(posedge CLK) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (we) begin
         mem_reg[wr_ptr] <= wr_data;
      end
   end

   // Read must be combinational: the head entry is presented in the same
   // cycle its filled bit is seen.
   assign rd_data = mem_reg[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Accepts fetch addresses from the PC stage, issues in-order reads to
// instruction memory and buffers the returned words with their PCs in a
// DEPTH-entry queue presented to decode. A flush discards queued entries and
// drops responses of fetches still in flight.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined   -> stall_cnt counts cycles with pc_valid && !pc_ready (saturating,
//                cleared by Reset only)
//   undefined -> stall_cnt is tied to zero
//
// Ports:
//   CLK, Reset               clock, synchronous active-high reset
//   pc_addr/pc_valid/pc_ready  fetch request handshake from the PC stage
//   imem_req/imem_addr       memory read strobe and address
//   imem_rvalid/imem_rdata   in-order memory responses (latency >= 1)
//   flush                    redirect: discard queued and in-flight fetches
//   inst_valid/inst_ready    head-entry handshake to decode
//   inst_pc/inst_data        head-entry PC and instruction
//   fq_err                   sticky: response arrived with nothing outstanding
//   stall_cnt                issue-stall cycle counter (see macro above)
// -----------------------------------------------------------------------------
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH  = FQ_DEPTH_DEF,
   parameter int ADDR_W = FQ_ADDR_W_DEF,
   parameter int DATA_W = FQ_DATA_W_DEF
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic              pc_valid,
   output logic              pc_ready,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              flush,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [DATA_W-1:0] inst_data,
   output logic              fq_err,
   output logic [31:0]       stall_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] SUM_ONE = 1;

   fq_state_t        state_reg, state_next;
   logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]    fill_ptr_reg, fill_ptr_next;
   logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]    alloc_cnt_reg, alloc_cnt_next;
   logic [CW-1:0]    pend_cnt_reg, pend_cnt_next;
   logic [CW-1:0]    drop_cnt_reg, drop_cnt_next;
   logic [DEPTH-1:0] filled_reg, filled_next;
   logic             fq_err_reg, fq_err_next;
   logic [CW:0]      drop_sum;

   logic             issue, pop, resp_fill;
   logic [ADDR_W-1:0] ring_pc;
   logic [DATA_W-1:0] ring_data;

   // Outputs are forced low while Reset is held, before the first reset edge
   // has cleared the state.
   assign pc_ready   = !Reset && (state_reg == FQ_RUN) && !flush &&
                       (alloc_cnt_reg < CW'(DEPTH));
   assign issue      = pc_valid && pc_ready;
   assign imem_req   = issue;
   assign imem_addr  = pc_addr;
   assign inst_valid = !Reset && filled_reg[rd_ptr_reg];
   assign inst_pc    = Reset ? '0 : ring_pc;
   assign inst_data  = Reset ? '0 : ring_data;
   assign fq_err     = fq_err_reg;

   // Flush overrides pop; responses are only written while a fetch is pending.
   assign pop       = inst_valid && inst_ready && !flush;
   assign resp_fill = imem_rvalid && !flush && (state_reg == FQ_RUN) &&
                      (pend_cnt_reg != '0);

   assign drop_sum = {1'b0, drop_cnt_reg} + {1'b0, pend_cnt_reg};

   always_comb begin
      state_next     = state_reg;
      wr_ptr_next    = wr_ptr_reg;
      fill_ptr_next  = fill_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      alloc_cnt_next = alloc_cnt_reg;
      pend_cnt_next  = pend_cnt_reg;
      drop_cnt_next  = drop_cnt_reg;
      filled_next    = filled_reg;
      fq_err_next    = fq_err_reg;

      if (flush) begin
         filled_next    = '0;
         alloc_cnt_next = '0;
         pend_cnt_next  = '0;
         wr_ptr_next    = '0;
         fill_ptr_next  = '0;
         rd_ptr_next    = '0;
         // Everything still pending becomes a response to discard; a response
         // arriving in the flush cycle itself is discarded immediately.
         if (imem_rvalid) begin
            if (drop_sum == '0) begin
               fq_err_next   = 1'b1;
               drop_cnt_next = '0;
            end else begin
               drop_cnt_next = CW'(drop_sum - SUM_ONE);
            end
         end else begin
            drop_cnt_next = CW'(drop_sum);
         end
         state_next = (drop_cnt_next != '0) ? FQ_DRAIN : FQ_RUN;
      end else begin
         if (issue) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            filled_next[rd_ptr_reg] = 1'b0;
            rd_ptr_next             = rd_ptr_reg + PW'(1);
         end
         if (imem_rvalid) begin
            if (state_reg == FQ_DRAIN) begin
               if (drop_cnt_reg <= CW'(1)) begin
                  drop_cnt_next = '0;
                  state_next    = FQ_RUN;
               end else begin
                  drop_cnt_next = drop_cnt_reg - CW'(1);
               end
            end else if (pend_cnt_reg != '0) begin
               filled_next[fill_ptr_reg] = 1'b1;
               fill_ptr_next             = fill_ptr_reg + PW'(1);
            end else begin
               fq_err_next = 1'b1;
            end
         end
         alloc_cnt_next = alloc_cnt_reg + CW'(issue) - CW'(pop);
         pend_cnt_next  = pend_cnt_reg + CW'(issue) - CW'(resp_fill);
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_reg     <= FQ_RUN;
         wr_ptr_reg    <= '0;
         fill_ptr_reg  <= '0;
         rd_ptr_reg    <= '0;
         alloc_cnt_reg <= '0;
         pend_cnt_reg  <= '0;
         drop_cnt_reg  <= '0;
         filled_reg    <= '0;
         fq_err_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         wr_ptr_reg    <= wr_ptr_next;
         fill_ptr_reg  <= fill_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         alloc_cnt_reg <= alloc_cnt_next;
         pend_cnt_reg  <= pend_cnt_next;
         drop_cnt_reg  <= drop_cnt_next;
         filled_reg    <= filled_next;
         fq_err_reg    <= fq_err_next;
      end
   end

   fq_ring #(
      .DEPTH (DEPTH),
      .W     (ADDR_W)
   ) u_pc_ring (
      .CLK     (CLK),
      .Reset   (Reset),
      .we      (issue),
      .wr_ptr  (wr_ptr_reg),
      .wr_data (pc_addr),
      .rd_ptr  (rd_ptr_reg),
      .rd_data (ring_pc)
   );

   fq_ring #(
      .DEPTH (DEPTH),
      .W     (DATA_W)
   ) u_data_ring (
      .CLK     (CLK),
      .Reset   (Reset),
      .we      (resp_fill),
      .wr_ptr  (fill_ptr_reg),
      .wr_data (imem_rdata),
      .rd_ptr  (rd_ptr_reg),
      .rd_data (ring_data)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_reg;

   // Not cleared by flush: counts every cycle the PC stage was held back.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         stall_cnt_reg <= '0;
      end else if (pc_valid && !pc_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
// Directed bench for inst_fetch_queue (DEPTH=4). Cycle tables cover streaming
// and back-pressure; hand-written sequences cover flush/drain, stray
// responses and the optional stall counter (FETCH_PERF_CNT_EN).
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] K = 32'hA5A5_A5A5;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] pc_addr = '0;
   logic        pc_valid = 1'b0;
   logic        pc_ready;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        flush = 1'b0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;
   logic        fq_err;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   inst_fetch_queue #(
      .DEPTH  (DEPTH),
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .pc_addr     (pc_addr),
      .pc_valid    (pc_valid),
      .pc_ready    (pc_ready),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .flush       (flush),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_pc     (inst_pc),
      .inst_data   (inst_data),
      .fq_err      (fq_err),
      .stall_cnt   (stall_cnt)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        pv;
      logic [31:0] pa;
      logic        rv;
      logic [31:0] rd;
      logic        ir;
      logic        fl;
      logic        e_pr;
      logic        e_req;
      logic        e_iv;
      logic [31:0] e_pc;
      logic [31:0] e_data;
      int          e_alloc;
   } vec_t;

   function automatic vec_t mk(logic pv, logic [31:0] pa, logic rv, logic [31:0] rd,
                               logic ir, logic fl, logic pr, logic req, logic iv,
                               logic [31:0] pc, logic [31:0] dat, int al);
      vec_t v;
      v.pv = pv; v.pa = pa; v.rv = rv; v.rd = rd; v.ir = ir; v.fl = fl;
      v.e_pr = pr; v.e_req = req; v.e_iv = iv; v.e_pc = pc; v.e_data = dat;
      v.e_alloc = al;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One cycle of stimulus: drive at the falling edge, sample 1 ns later.
   task automatic cyc(input logic pv, input logic [31:0] pa, input logic rv,
                      input logic [31:0] rd, input logic ir, input logic fl);
      @(negedge CLK);
      pc_valid = pv; pc_addr = pa; imem_rvalid = rv; imem_rdata = rd;
      inst_ready = ir; flush = fl;
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      Reset = 1'b1; pc_valid = 1'b1; pc_addr = 32'h55; imem_rvalid = 1'b0;
      imem_rdata = '0; flush = 1'b0; inst_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst pc_ready", pc_ready, 0);
      chk("rst imem_req", imem_req, 0);
      chk("rst inst_valid", inst_valid, 0);
      chk("rst inst_pc", inst_pc, 0);
      chk("rst inst_data", inst_data, 0);
      chk("rst fq_err", fq_err, 0);
      chk("rst stall_cnt", stall_cnt, 0);
      @(negedge CLK);
      Reset = 1'b0; pc_valid = 1'b0;
      #1;
      chk("post-rst pc_ready", pc_ready, 1);
      chk("post-rst inst_valid", inst_valid, 0);
      $display("reset applied");
   endtask

   task automatic run_vec(input string tag, input int idx, input vec_t v);
      @(negedge CLK);
      pc_valid = v.pv; pc_addr = v.pa; imem_rvalid = v.rv; imem_rdata = v.rd;
      inst_ready = v.ir; flush = v.fl;
      #1;
      chk($sformatf("%s[%0d] pc_ready", tag, idx), pc_ready, v.e_pr);
      chk($sformatf("%s[%0d] imem_req", tag, idx), imem_req, v.e_req);
      if (v.e_req) chk($sformatf("%s[%0d] imem_addr", tag, idx), imem_addr, v.pa);
      chk($sformatf("%s[%0d] inst_valid", tag, idx), inst_valid, v.e_iv);
      if (v.e_iv) begin
         chk($sformatf("%s[%0d] inst_pc", tag, idx), inst_pc, v.e_pc);
         chk($sformatf("%s[%0d] inst_data", tag, idx), inst_data, v.e_data);
      end
      chk($sformatf("%s[%0d] alloc_cnt", tag, idx), 64'(dut.alloc_cnt_reg), 64'(v.e_alloc));
      $display("%s[%0d] pv=%0b pa=%0h rv=%0b ir=%0b -> pr=%0b req=%0b iv=%0b pc=%0h data=%0h",
               tag, idx, v.pv, v.pa, v.rv, v.ir, pc_ready, imem_req, inst_valid,
               inst_pc, inst_data);
   endtask

   initial begin
      vec_t t1[$];
      vec_t t2[$];

      // Streaming, 1-cycle memory, decode always ready.
      //              pv  pa     rv  rd           ir fl  pr req iv pc     data        alloc
      t1.push_back(mk(1, 32'h0, 0, 32'h0,       1, 0,  1, 1,  0, 32'h0, 32'h0,      0));
      t1.push_back(mk(1, 32'h4, 1, 32'h0 ^ K,   1, 0,  1, 1,  0, 32'h0, 32'h0,      1));
      t1.push_back(mk(1, 32'h8, 1, 32'h4 ^ K,   1, 0,  1, 1,  1, 32'h0, 32'h0 ^ K,  2));
      t1.push_back(mk(0, 32'h0, 1, 32'h8 ^ K,   1, 0,  1, 0,  1, 32'h4, 32'h4 ^ K,  2));
      t1.push_back(mk(0, 32'h0, 0, 32'h0,       1, 0,  1, 0,  1, 32'h8, 32'h8 ^ K,  1));
      t1.push_back(mk(0, 32'h0, 0, 32'h0,       1, 0,  1, 0,  0, 32'h0, 32'h0,      0));

      // Back-pressure: queue fills, pop does not bypass issue in the same cycle.
      t2.push_back(mk(1, 32'h0,  0, 32'h0,       0, 0,  1, 1,  0, 32'h0, 32'h0,     0));
      t2.push_back(mk(1, 32'h4,  1, 32'h0 ^ K,   0, 0,  1, 1,  0, 32'h0, 32'h0,     1));
      t2.push_back(mk(1, 32'h8,  1, 32'h4 ^ K,   0, 0,  1, 1,  1, 32'h0, 32'h0 ^ K, 2));
      t2.push_back(mk(1, 32'hC,  1, 32'h8 ^ K,   0, 0,  1, 1,  1, 32'h0, 32'h0 ^ K, 3));
      t2.push_back(mk(1, 32'h10, 1, 32'hC ^ K,   0, 0,  0, 0,  1, 32'h0, 32'h0 ^ K, 4));
      t2.push_back(mk(1, 32'h10, 0, 32'h0,       0, 0,  0, 0,  1, 32'h0, 32'h0 ^ K, 4));
      t2.push_back(mk(1, 32'h10, 0, 32'h0,       1, 0,  0, 0,  1, 32'h0, 32'h0 ^ K, 4));
      t2.push_back(mk(1, 32'h10, 0, 32'h0,       0, 0,  1, 1,  1, 32'h4, 32'h4 ^ K, 3));
      t2.push_back(mk(0, 32'h0,  1, 32'h10 ^ K,  1, 0,  0, 0,  1, 32'h4, 32'h4 ^ K, 4));
      t2.push_back(mk(0, 32'h0,  0, 32'h0,       1, 0,  1, 0,  1, 32'h8, 32'h8 ^ K, 3));

      do_reset();
      foreach (t1[i]) run_vec("stream", i, t1[i]);

      do_reset();
      foreach (t2[i]) run_vec("full", i, t2[i]);

      // Flush on the cycle the first of two 3-cycle responses arrives.
      do_reset();
      cyc(1, 32'h100, 0, 0, 0, 0);
      chk("t3 issue 0x100 pc_ready", pc_ready, 1);
      cyc(1, 32'h104, 0, 0, 0, 0);
      chk("t3 issue 0x104 pc_ready", pc_ready, 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t3 wait inst_valid", inst_valid, 0);
      cyc(0, 0, 1, 32'h100 ^ K, 0, 1);
      chk("t3 flush pc_ready", pc_ready, 0);
      chk("t3 flush inst_valid", inst_valid, 0);
      cyc(0, 0, 1, 32'h104 ^ K, 0, 0);
      chk("t3 drain state", 64'(dut.state_reg), 1);
      chk("t3 drain drop_cnt", 64'(dut.drop_cnt_reg), 1);
      chk("t3 drain pc_ready", pc_ready, 0);
      chk("t3 drain inst_valid", inst_valid, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("t3 after drop state", 64'(dut.state_reg), 0);
      chk("t3 after drop pc_ready", pc_ready, 1);
      chk("t3 after drop inst_valid", inst_valid, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("t3 idle inst_valid", inst_valid, 0);
      $display("t3 flush with same-cycle response done");

      // Second flush while draining, with no response in that cycle.
      do_reset();
      cyc(1, 32'h200, 0, 0, 0, 0);
      cyc(1, 32'h204, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("t4 first flush drop_cnt", 64'(dut.drop_cnt_reg), 2);
      chk("t4 first flush state", 64'(dut.state_reg), 1);
      cyc(0, 0, 1, 32'h200 ^ K, 0, 0);
      chk("t4 second flush drop_cnt", 64'(dut.drop_cnt_reg), 2);
      chk("t4 second flush pc_ready", pc_ready, 0);
      cyc(0, 0, 1, 32'h204 ^ K, 0, 0);
      chk("t4 one dropped drop_cnt", 64'(dut.drop_cnt_reg), 1);
      chk("t4 one dropped pc_ready", pc_ready, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t4 drained drop_cnt", 64'(dut.drop_cnt_reg), 0);
      chk("t4 drained state", 64'(dut.state_reg), 0);
      chk("t4 drained pc_ready", pc_ready, 1);
      $display("t4 flush during drain done");

      // Stray response with nothing outstanding.
      do_reset();
      cyc(1, 32'h300, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h300 ^ K, 0, 0);
      cyc(0, 0, 1, 32'hDEAD_BEEF, 0, 0);
      chk("t5 before stray fq_err", fq_err, 0);
      chk("t5 before stray inst_pc", inst_pc, 32'h300);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t5 stray fq_err", fq_err, 1);
      chk("t5 stray inst_valid", inst_valid, 1);
      chk("t5 stray inst_pc", inst_pc, 32'h300);
      chk("t5 stray inst_data", inst_data, 32'h300 ^ K);
      chk("t5 stray alloc_cnt", 64'(dut.alloc_cnt_reg), 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("t5 sticky after flush fq_err", fq_err, 1);
      repeat (3) cyc(0, 0, 0, 0, 0, 0);
      chk("t5 sticky later fq_err", fq_err, 1);
      do_reset();
      chk("t5 cleared by reset fq_err", fq_err, 0);
      $display("t5 stray response done");

      // Stall counter: fill the queue, then hold pc_valid for 10 blocked cycles.
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, 32'(i * 4), 0, 0, 0, 0);
      end
      for (int i = 0; i < 10; i++) begin
         cyc(1, 32'h40, 0, 0, 0, 0);
      end
      chk("t6 blocked pc_ready", pc_ready, 0);
      cyc(0, 0, 0, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
      chk("t6 stall_cnt", stall_cnt, 10);
`else
      chk("t6 stall_cnt", stall_cnt, 0);
`endif
      $display("t6 stall_cnt=%0d", stall_cnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
